button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/btn_pkg.sv | 21 ++
 rtl/button_conditioner_if.sv | 24 ++
 rtl/btn_debounce.sv | 122 ++++++++++++
 rtl/button_conditioner.sv | 56 +++++
 4 files changed

// File: rtl/btn_pkg.sv
// Button conditioner shared definitions.
// FSM state encoding, default timing and counter widths.
package btn_pkg;

    typedef enum logic [2:0] {
        ST_RELEASED    = 3'd0,
        ST_PRESS_CHK   = 3'd1,
        ST_HELD        = 3'd2,
        ST_REPEAT      = 3'd3,
        ST_RELEASE_CHK = 3'd4
    } btn_state_e;

    localparam int DEF_NBTN            = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;

    localparam int DB_W = 24;
    localparam int TM_W = 32;

endpackage

// File: rtl/button_conditioner_if.sv
// Button pins in, debounced level and pulses out.
// master drives the raw pins, slave is the conditioner.
interface button_conditioner_if #(
    parameter int NBTN = btn_pkg::DEF_NBTN
);
    logic [NBTN-1:0] PushButtonRaw;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] PushButton;
    logic [NBTN-1:0] repeat_active;

    modport master (
        output PushButtonRaw,
        input  btn_level,
        input  PushButton,
        input  repeat_active
    );

    modport slave (
        input  PushButtonRaw,
        output btn_level,
        output PushButton,
        output repeat_active
    );
endinterface

// File: rtl/btn_debounce.sv
// One button: synchronizer, debounce FSM, hold/repeat timing.
// req is a single-cycle combinational press/repeat request.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic CLK,
    input  logic RESET,
    input  logic raw,
    output logic level,
    output logic repeat_active,
    output logic req
);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
    localparam logic [TM_W-1:0] HOLD_END = TM_W'(REPEAT_DELAY);
    localparam logic [TM_W-1:0] RPT_END  = TM_W'(REPEAT_PERIOD);
    localparam logic [TM_W-1:0] TM_ONE   = TM_W'(1);
    localparam bit              RPT_EN   = REPEAT_PERIOD != 0;

    logic [1:0]      sync_q;
    logic            din;
    btn_state_e      state_q, state_d;
    logic [DB_W-1:0] db_q, db_d;
    logic [TM_W-1:0] hold_q, hold_d;
    logic [TM_W-1:0] rpt_q, rpt_d;

    assign din           = sync_q[1];
    assign level         = state_q inside {ST_HELD, ST_REPEAT,
                                           ST_RELEASE_CHK};
    assign repeat_active = state_q == ST_REPEAT;

    // two-flop synchronizer for the asynchronous pin
    always_ff @(posedge CLK) begin
        if (!RESET) sync_q <= '0;
        else        sync_q <= {sync_q[0], raw};
    end

    // state and counter registers
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_RELEASED;
            db_q    <= '0;
            hold_q  <= '0;
            rpt_q   <= '0;
        end else begin
            state_q <= state_d;
            db_q    <= db_d;
            hold_q  <= hold_d;
            rpt_q   <= rpt_d;
        end
    end

    // next state, counters and request
    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        hold_d  = hold_q;
        rpt_d   = rpt_q;
        req     = 1'b0;
        unique case (state_q)
            ST_RELEASED: begin
                if (din) begin
                    state_d = ST_PRESS_CHK;
                    db_d    = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!din) begin
                    state_d = ST_RELEASED;
                end else if (db_q == DB_LAST) begin
                    state_d = ST_HELD;
                    hold_d  = '0;
                    rpt_d   = '0;
                    req     = 1'b1;
                end else begin
                    db_d = db_q + DB_ONE;
                end
            end
            ST_HELD: begin
                if (!din) begin
                    state_d = ST_RELEASE_CHK;
                    db_d    = '0;
                end else if (hold_q != HOLD_END) begin
                    hold_d = hold_q + TM_ONE;
                    if (RPT_EN && hold_d == HOLD_END) begin
                        state_d = ST_REPEAT;
                        req     = 1'b1;
                    end
                end
            end
            ST_REPEAT: begin
                if (!din) begin
                    state_d = ST_RELEASE_CHK;
                    db_d    = '0;
                end else if (rpt_q + TM_ONE >= RPT_END) begin
                    rpt_d = '0;
                    req   = 1'b1;
                end else begin
                    rpt_d = rpt_q + TM_ONE;
                end
            end
            ST_RELEASE_CHK: begin
                if (din) begin
                    // hold saturates at the delay, so it marks REPEAT
                    if (RPT_EN && hold_q == HOLD_END)
                        state_d = ST_REPEAT;
                    else
                        state_d = ST_HELD;
                end else if (db_q == DB_LAST) begin
                    state_d = ST_RELEASED;
                end else begin
                    db_d = db_q + DB_ONE;
                end
            end
            default: state_d = ST_RELEASED;
        endcase
    end
endmodule

// File: rtl/button_conditioner.sv
// Debounced buttons with auto-repeat and one-hot pulse output.
// Requests queue in pending bits; lowest index issues first.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int NBTN            = DEF_NBTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input logic                CLK,
    input logic                RESET,
    button_conditioner_if.slave bus
);
    logic [NBTN-1:0] req;
    logic [NBTN-1:0] lvl;
    logic [NBTN-1:0] rpt;
    logic [NBTN-1:0] cand;
    logic [NBTN-1:0] grant;
    logic [NBTN-1:0] pend_q;
    logic [NBTN-1:0] pb_q;

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_db (
            .CLK          (CLK),
            .RESET        (RESET),
            .raw          (bus.PushButtonRaw[i]),
            .level        (lvl[i]),
            .repeat_active(rpt[i]),
            .req          (req[i])
        );
    end

    // a bit that pulsed last cycle sits out one cycle
    assign cand  = (pend_q | req) & ~pb_q;
    assign grant = cand & (~cand + NBTN'(1));

    assign bus.btn_level     = lvl;
    assign bus.repeat_active = rpt;
    assign bus.PushButton    = pb_q;

    // pending bits and registered one-hot pulse
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pend_q <= '0;
            pb_q   <= '0;
        end else begin
            pend_q <= (pend_q | req) & ~grant;
            pb_q   <= grant;
        end
    end
endmodule
